// File: rtl/video_timing_pkg.sv
// Shared definitions for the video timing controller: FSM state encoding
// and the default 1280x720 timing constants (pixels / lines).
// Imported by video_timing_ctrl.
package video_timing_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } vt_state_t;

    // 720p horizontal timing, in pixels
    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_FP     = 110;
    localparam int DEF_H_SYNC   = 40;
    localparam int DEF_H_BP     = 220;

    // 720p vertical timing, in lines
    localparam int DEF_V_ACTIVE = 720;
    localparam int DEF_V_FP     = 5;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BP     = 20;

endpackage

// File: rtl/video_timing_ctrl.sv
// Purpose: raster timing generator (hsync/vsync/video_enable, sx/sy, strobes) on the pixel clock.
// Latency: every output registered and mutually aligned; first pixel (0,0) one clock after run is seen in IDLE.
// Backpressure: none; run is a level request, frames are never truncated, only reset abandons a frame.
//
// Ports: video_clk_pix (only clock), video_rst (async active-high), run (level request),
//        busy, hsync, vsync, video_enable, sx, sy, line_start, frame_start.
// Optional: define VIDEO_TIMING_CTRL_PREFETCH_EN to add sx_next/sy_next, the
//        coordinates sx/sy will show one cycle later (for a one-stage pipelined pattern generator).
module video_timing_ctrl
    import video_timing_pkg::*;
#(
    parameter int CORDW    = 16,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic             video_clk_pix,
    input  logic             video_rst,
    input  logic             run,
    output logic             busy,
    output logic             hsync,
    output logic             vsync,
    output logic             video_enable,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             line_start,
    output logic             frame_start
`ifdef VIDEO_TIMING_CTRL_PREFETCH_EN
    ,
    output logic [CORDW-1:0] sx_next,
    output logic [CORDW-1:0] sy_next
`endif
);

    typedef logic [CORDW-1:0] cord_t;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam cord_t ONE        = cord_t'(1);
    localparam cord_t H_LAST     = cord_t'(H_TOTAL - 1);
    localparam cord_t V_LAST     = cord_t'(V_TOTAL - 1);
    localparam cord_t H_ACT_END  = cord_t'(H_ACTIVE);
    localparam cord_t V_ACT_END  = cord_t'(V_ACTIVE);
    localparam cord_t H_SYNC_BEG = cord_t'(H_ACTIVE + H_FP);
    localparam cord_t H_SYNC_END = cord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cord_t V_SYNC_BEG = cord_t'(V_ACTIVE + V_FP);
    localparam cord_t V_SYNC_END = cord_t'(V_ACTIVE + V_FP + V_SYNC);

    // Half-open range test [lo, hi)
    function automatic logic in_range(input cord_t v, input cord_t lo, input cord_t hi);
        return (v >= lo) && (v < hi);
    endfunction

    function automatic logic h_active(input cord_t x);
        return x < H_ACT_END;
    endfunction

    function automatic logic v_active(input cord_t y);
        return y < V_ACT_END;
    endfunction

    function automatic logic h_sync_zone(input cord_t x);
        return in_range(x, H_SYNC_BEG, H_SYNC_END);
    endfunction

    function automatic logic v_sync_zone(input cord_t y);
        return in_range(y, V_SYNC_BEG, V_SYNC_END);
    endfunction

    vt_state_t state;

    logic  line_last;
    logic  frame_last;
    logic  start;
    logic  advance;
    logic  pix_on;
    cord_t pix_x;
    cord_t pix_y;

    // Coordinates of the pixel to be presented after the next edge.
    // The only decision point inside a frame is its last pixel: run high
    // wraps straight into the next frame, run low returns to IDLE. Any run
    // activity before that only moves the FSM between RUN and DRAIN.
    always_comb begin
        line_last  = (sx == H_LAST);
        frame_last = line_last && (sy == V_LAST);
        start      = (state == ST_IDLE) && run;
        advance    = (state != ST_IDLE) && !(frame_last && !run);
        pix_on     = start || advance;
        pix_x      = '0;
        pix_y      = '0;
        if (advance && !line_last) begin
            pix_x = sx + ONE;
            pix_y = sy;
        end else if (advance && !frame_last) begin
            pix_y = sy + ONE;
        end
        // start, frame wrap and going idle all leave (0,0)
    end

    always_ff @(posedge video_clk_pix or posedge video_rst) begin
        if (video_rst) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            sx           <= '0;
            sy           <= '0;
            video_enable <= 1'b0;
            hsync        <= ~SYNC_POL;
            vsync        <= ~SYNC_POL;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!run) state <= frame_last ? ST_IDLE : ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (run)             state <= ST_RUN;
                    else if (frame_last) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            // pix_on is exactly "next state is not IDLE"
            busy         <= pix_on;
            sx           <= pix_x;
            sy           <= pix_y;
            video_enable <= pix_on && h_active(pix_x) && v_active(pix_y);
            hsync        <= (pix_on && h_sync_zone(pix_x)) ? SYNC_POL : ~SYNC_POL;
            vsync        <= (pix_on && v_sync_zone(pix_y)) ? SYNC_POL : ~SYNC_POL;
            line_start   <= pix_on && (pix_x == '0);
            frame_start  <= pix_on && (pix_x == '0) && (pix_y == '0);
        end
    end

`ifdef VIDEO_TIMING_CTRL_PREFETCH_EN
    // Lookahead coordinate: successor of the pixel being loaded into sx/sy.
    // After the last pixel of a frame the successor is (0,0) whether the
    // controller continues or returns to IDLE, so no knowledge of future run
    // is needed. In IDLE it stays 0, which is also the first pixel shown.
    always_ff @(posedge video_clk_pix or posedge video_rst) begin
        if (video_rst) begin
            sx_next <= '0;
            sy_next <= '0;
        end else if (pix_on) begin
            if (pix_x == H_LAST) begin
                sx_next <= '0;
                sy_next <= (pix_y == V_LAST) ? '0 : pix_y + ONE;
            end else begin
                sx_next <= pix_x + ONE;
                sy_next <= pix_y;
            end
        end else begin
            sx_next <= '0;
            sy_next <= '0;
        end
    end
`else
    // No lookahead outputs in this build.
`endif

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl with an 8x6 raster (H 4/1/2/1, V 3/1/1/1),
// one instance per sync polarity driven from the same run/reset.
module tb_video_timing_ctrl;

    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;

    always #5 clk = ~clk;

    logic          busy, hsync, vsync, ve, ls, fs;
    logic [CW-1:0] sx, sy;
    logic          busy_n, hsync_n, vsync_n, ve_n, ls_n, fs_n;
    logic [CW-1:0] sx_n, sy_n;

    video_timing_ctrl #(
        .CORDW(CW), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
    ) dut (
        .video_clk_pix(clk), .video_rst(rst), .run(run), .busy(busy),
        .hsync(hsync), .vsync(vsync), .video_enable(ve), .sx(sx), .sy(sy),
        .line_start(ls), .frame_start(fs)
    );

    video_timing_ctrl #(
        .CORDW(CW), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
    ) dut_n (
        .video_clk_pix(clk), .video_rst(rst), .run(run), .busy(busy_n),
        .hsync(hsync_n), .vsync(vsync_n), .video_enable(ve_n), .sx(sx_n), .sy(sy_n),
        .line_start(ls_n), .frame_start(fs_n)
    );

    typedef struct {
        int   k;
        int   ex, ey;
        logic eve, ehs, evs, els, efs;
    } vec_t;

    vec_t tbl[12];

    int total = 0;
    int bad   = 0;
    int k;
    int last_fs;
    int fs_cnt, ve_cnt, hs_cnt, vs_cnt, busy_cnt;
    int lx, ly;
    logic found;

    task automatic check_i(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_b(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_b({tag, " busy"}, busy, 1'b0);
        check_i({tag, " sx"}, int'(sx), 0);
        check_i({tag, " sy"}, int'(sy), 0);
        check_b({tag, " ve"}, ve, 1'b0);
        check_b({tag, " hs"}, hsync, 1'b0);
        check_b({tag, " vs"}, vsync, 1'b0);
        check_b({tag, " ls"}, ls, 1'b0);
        check_b({tag, " fs"}, fs, 1'b0);
        check_b({tag, " hs_n"}, hsync_n, 1'b1);
        check_b({tag, " vs_n"}, vsync_n, 1'b1);
    endtask

    // Expected outputs for pixel number kk counted from a frame start.
    task automatic check_model(input string tag, input int kk);
        int   x, y;
        logic e_hs, e_vs;
        x    = kk % 8;
        y    = (kk / 8) % 6;
        e_hs = (x == 5) || (x == 6);
        e_vs = (y == 4);
        check_b({tag, " busy"}, busy, 1'b1);
        check_i({tag, " sx"}, int'(sx), x);
        check_i({tag, " sy"}, int'(sy), y);
        check_b({tag, " ve"}, ve, (x < 4) && (y < 3));
        check_b({tag, " hs"}, hsync, e_hs);
        check_b({tag, " vs"}, vsync, e_vs);
        check_b({tag, " ls"}, ls, x == 0);
        check_b({tag, " fs"}, fs, (x == 0) && (y == 0));
        check_b({tag, " hs_n"}, hsync_n, !e_hs);
        check_b({tag, " vs_n"}, vsync_n, !e_vs);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            k   sx sy  ve    hs    vs    ls    fs
        tbl[0]  = '{0,  0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[1]  = '{3,  3, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{4,  4, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{5,  5, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{6,  6, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{7,  7, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{8,  0, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{25, 1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{33, 1, 4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{37, 5, 4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{47, 7, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{48, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset state
        rst = 1'b1;
        run = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        #2 rst = 1'b0;
        tick;
        tick;
        check_idle("idle_norun");

        // Continuous run: directed vectors over the first frame
        run = 1'b1;
        k   = -1;
        for (int i = 0; i < 12; i++) begin
            while (k < tbl[i].k) begin
                tick;
                k++;
            end
            check_b("vec busy", busy, 1'b1);
            check_i("vec sx", int'(sx), tbl[i].ex);
            check_i("vec sy", int'(sy), tbl[i].ey);
            check_b("vec ve", ve, tbl[i].eve);
            check_b("vec hs", hsync, tbl[i].ehs);
            check_b("vec vs", vsync, tbl[i].evs);
            check_b("vec ls", ls, tbl[i].els);
            check_b("vec fs", fs, tbl[i].efs);
            check_b("vec hs_n", hsync_n, !tbl[i].ehs);
            check_b("vec vs_n", vsync_n, !tbl[i].evs);
        end

        // Two more frames checked cycle by cycle; counts over frames at k=96..191
        last_fs = 48;
        fs_cnt = 0; ve_cnt = 0; hs_cnt = 0; vs_cnt = 0;
        while (k < 191) begin
            tick;
            k++;
            check_model("run", k);
            if (fs) begin
                check_i("fs_period", k - last_fs, 48);
                last_fs = k;
            end
            if (k >= 96) begin
                fs_cnt += int'(fs);
                ve_cnt += int'(ve);
                hs_cnt += int'(hsync);
                vs_cnt += int'(vsync);
            end
        end
        check_i("fs_count_2frames", fs_cnt, 2);
        check_i("ve_count_2frames", ve_cnt, 24);
        check_i("hs_count_2frames", hs_cnt, 24);
        check_i("vs_count_2frames", vs_cnt, 16);

        // run dropped then reasserted inside the frame: no gap, busy stays high
        while (k < 240) begin
            tick;
            k++;
            check_model("drain_back", k);
            if (k == 200) run = 1'b0;
            if (k == 220) run = 1'b1;
        end

        // run dropped: current frame completes, then IDLE
        run = 1'b0;
        while (k < 287) begin
            tick;
            k++;
            check_model("drain_end", k);
        end
        tick;
        check_idle("drained");

        // Short run pulse: exactly one frame
        run = 1'b1;
        busy_cnt = 0; fs_cnt = 0; ve_cnt = 0; lx = -1; ly = -1;
        for (int i = 0; i < 60; i++) begin
            tick;
            if (i == 2) run = 1'b0;
            if (busy) begin
                busy_cnt++;
                fs_cnt += int'(fs);
                ve_cnt += int'(ve);
                lx = int'(sx);
                ly = int'(sy);
            end
        end
        check_i("pulse busy_cycles", busy_cnt, 48);
        check_i("pulse frame_starts", fs_cnt, 1);
        check_i("pulse ve_cycles", ve_cnt, 12);
        check_i("pulse last_sx", lx, 7);
        check_i("pulse last_sy", ly, 5);
        check_idle("pulse_end");

        // Asynchronous reset mid-frame at (3,1)
        run   = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick;
            if (busy && sx == 16'd3 && sy == 16'd1) found = 1'b1;
        end
        check_b("rst_wait reached (3,1)", found, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_idle("async_rst");
        run = 1'b0;
        #2 rst = 1'b0;
        tick;
        tick;
        check_idle("post_rst_norun");
        run = 1'b1;
        tick;
        check_model("restart", 0);
        run = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
